// File: rtl/wm_block_scheduler_pkg.sv
// Shared types and constants for the watermark block scheduler.
// Holds the FSM state type, the pixel-bank layout and the configuration legality check.
package wm_block_scheduler_pkg;

    localparam int AMBA_ADDR_DEPTH = 20;
    localparam int DATA_DEPTH      = 8;
    localparam int BLOCK_DEPTH     = 7;
    localparam int DIM_DEPTH       = 10;
    localparam int PIX_BASE        = 10;
    localparam int SPAN_W          = 2 * BLOCK_DEPTH;

    // Parameter words occupying bank addresses 1..9.
    localparam int ADDR_IWHITE = 1;
    localparam int ADDR_NP     = 2;
    localparam int ADDR_NW     = 3;
    localparam int ADDR_M      = 4;
    localparam int ADDR_BTHR   = 5;
    localparam int ADDR_AMIN   = 6;
    localparam int ADDR_AMAX   = 7;
    localparam int ADDR_BMIN   = 8;
    localparam int ADDR_BMAX   = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STAT,
        ST_WAIT_STAT,
        ST_MIX,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

    // A grid that is empty or wider than the image cannot be walked.
    function automatic logic cfg_illegal(input logic [DIM_DEPTH-1:0]   np,
                                         input logic [BLOCK_DEPTH-1:0] m,
                                         input logic [BLOCK_DEPTH-1:0] blk);
        logic [SPAN_W-1:0] span;
        span = SPAN_W'(m) * SPAN_W'(blk);
        return (m == '0) || (blk == '0) || (span > SPAN_W'(np));
    endfunction

endpackage

// File: rtl/wm_pix_addr_gen.sv
// Raster address generator: c/r within a block, bx/by across blocks.
// Rows advance by adding Np to a running base, so no multiply sits in the per-pixel path.
module wm_pix_addr_gen
    import wm_block_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_init,
    input  logic                       i_adv,
    input  logic                       i_next_block,
    input  logic [DIM_DEPTH-1:0]       i_np,
    input  logic [BLOCK_DEPTH-1:0]     i_m,
    input  logic [BLOCK_DEPTH-1:0]     i_blk,
    output logic [AMBA_ADDR_DEPTH-1:0] o_addr_p,
    output logic [AMBA_ADDR_DEPTH-1:0] o_addr_w,
    output logic                       o_last_pix,
    output logic                       o_last_blk
);

    localparam int AW = AMBA_ADDR_DEPTH;
    localparam logic [BLOCK_DEPTH-1:0] ONE = BLOCK_DEPTH'(1);

    logic [DIM_DEPTH-1:0]   r_np;
    logic [BLOCK_DEPTH-1:0] r_m, r_blk;
    logic [BLOCK_DEPTH-1:0] r_c, r_r, r_bx, r_by;
    logic [AW-1:0]          r_col_base, r_row_base, r_blkrow_base, r_next_blkrow, r_np_sq;

    logic [AW-1:0]          w_np_ext, w_blk_ext;
    logic [BLOCK_DEPTH-1:0] w_blk_max, w_m_max;

    assign w_np_ext  = AW'(r_np);
    assign w_blk_ext = AW'(r_blk);
    assign w_blk_max = r_blk - ONE;
    assign w_m_max   = r_m - ONE;

    assign o_addr_p   = r_row_base + r_col_base + AW'(r_c);
    assign o_addr_w   = o_addr_p + r_np_sq;
    assign o_last_pix = (r_c == w_blk_max) && (r_r == w_blk_max);
    assign o_last_blk = (r_bx == w_m_max) && (r_by == w_m_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_np          <= '0;
            r_m           <= '0;
            r_blk         <= '0;
            r_c           <= '0;
            r_r           <= '0;
            r_bx          <= '0;
            r_by          <= '0;
            r_col_base    <= '0;
            r_row_base    <= '0;
            r_blkrow_base <= '0;
            r_next_blkrow <= '0;
            r_np_sq       <= '0;
        end else if (i_init) begin
            r_np          <= i_np;
            r_m           <= i_m;
            r_blk         <= i_blk;
            r_c           <= '0;
            r_r           <= '0;
            r_bx          <= '0;
            r_by          <= '0;
            r_col_base    <= '0;
            r_row_base    <= AW'(PIX_BASE);
            r_blkrow_base <= AW'(PIX_BASE);
            r_next_blkrow <= AW'(PIX_BASE);
            r_np_sq       <= AW'(i_np) * AW'(i_np);
        end else if (i_adv) begin
            if (r_c == w_blk_max) begin
                r_c <= '0;
                if (r_r == w_blk_max) begin
                    // End of a pass: rewind to the block's top row, remember the next block row.
                    r_r           <= '0;
                    r_row_base    <= r_blkrow_base;
                    r_next_blkrow <= r_row_base + w_np_ext;
                end else begin
                    r_r        <= r_r + ONE;
                    r_row_base <= r_row_base + w_np_ext;
                end
            end else begin
                r_c <= r_c + ONE;
            end
        end else if (i_next_block) begin
            if (r_bx == w_m_max) begin
                r_bx          <= '0;
                r_by          <= r_by + ONE;
                r_col_base    <= '0;
                r_blkrow_base <= r_next_blkrow;
                r_row_base    <= r_next_blkrow;
            end else begin
                r_bx       <= r_bx + ONE;
                r_col_base <= r_col_base + w_blk_ext;
            end
        end
    end

endmodule

// File: rtl/wm_block_scheduler.sv
// Per-block sequencer: statistics pass, wait for alpha/beta, then mix pass, over all M*M blocks.
// Valid/last strobes are delayed one cycle to line up with the bank's registered read data.
module wm_block_scheduler
    import wm_block_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic [DIM_DEPTH-1:0]       i_np,
    input  logic [BLOCK_DEPTH-1:0]     i_m,
    input  logic [BLOCK_DEPTH-1:0]     i_blk,
    output logic                       o_rd_en,
    output logic [AMBA_ADDR_DEPTH-1:0] o_rd_addr_p,
    output logic [AMBA_ADDR_DEPTH-1:0] o_rd_addr_w,
    output logic                       o_stat_valid,
    output logic                       o_stat_last,
    input  logic                       i_stat_done,
    input  logic                       i_mix_ready,
    output logic                       o_mix_valid,
    output logic                       o_mix_last,
    output logic                       o_busy,
    output logic                       o_image_done,
    output logic                       o_cfg_err
);

    sched_state_e r_state, w_state_next;
    logic r_cfg_err, w_cfg_err_next;
    logic r_stat_valid, r_stat_last, r_mix_valid, r_mix_last;
    logic w_init, w_adv, w_next_block, w_stat_rd, w_mix_rd, w_illegal;
    logic w_last_pix, w_last_blk;

    assign w_illegal = cfg_illegal(i_np, i_m, i_blk);

    wm_pix_addr_gen u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_init       (w_init),
        .i_adv        (w_adv),
        .i_next_block (w_next_block),
        .i_np         (i_np),
        .i_m          (i_m),
        .i_blk        (i_blk),
        .o_addr_p     (o_rd_addr_p),
        .o_addr_w     (o_rd_addr_w),
        .o_last_pix   (w_last_pix),
        .o_last_blk   (w_last_blk)
    );

    always_comb begin
        w_state_next   = r_state;
        w_cfg_err_next = r_cfg_err;
        w_init         = 1'b0;
        w_adv          = 1'b0;
        w_next_block   = 1'b0;
        w_stat_rd      = 1'b0;
        w_mix_rd       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_cfg_err_next = w_illegal;
                    if (w_illegal) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_init       = 1'b1;
                        w_state_next = ST_STAT;
                    end
                end
            end
            ST_STAT: begin
                w_stat_rd = 1'b1;
                w_adv     = 1'b1;
                if (w_last_pix) w_state_next = ST_WAIT_STAT;
            end
            ST_WAIT_STAT: begin
                if (i_stat_done) w_state_next = ST_MIX;
            end
            ST_MIX: begin
                // The mixer's lookahead ready gates both the read and the address step.
                w_mix_rd = i_mix_ready;
                w_adv    = i_mix_ready;
                if (i_mix_ready && w_last_pix) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_last_blk) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_next_block = 1'b1;
                    w_state_next = ST_STAT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cfg_err    <= 1'b0;
            r_stat_valid <= 1'b0;
            r_stat_last  <= 1'b0;
            r_mix_valid  <= 1'b0;
            r_mix_last   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cfg_err    <= w_cfg_err_next;
            r_stat_valid <= w_stat_rd;
            r_stat_last  <= w_stat_rd && w_last_pix;
            r_mix_valid  <= w_mix_rd;
            r_mix_last   <= w_mix_rd && w_last_pix;
        end
    end

    assign o_rd_en      = w_stat_rd || w_mix_rd;
    assign o_stat_valid = r_stat_valid;
    assign o_stat_last  = r_stat_last;
    assign o_mix_valid  = r_mix_valid;
    assign o_mix_last   = r_mix_last;
    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_image_done = (r_state == ST_DONE);
    assign o_cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_wm_block_scheduler.sv
// Directed and randomized checks of wm_block_scheduler against a raster-order read list
// built from row/column arithmetic; inputs change #1 after posedge, outputs sampled at negedge.
module tb_wm_block_scheduler;

    localparam int BOUND = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stat_done = 1'b0;
    logic        mix_ready = 1'b0;
    logic [9:0]  np = '0;
    logic [6:0]  m = '0;
    logic [6:0]  blk = '0;
    logic        o_rd_en, o_stat_valid, o_stat_last, o_mix_valid, o_mix_last;
    logic        o_busy, o_image_done, o_cfg_err;
    logic [19:0] o_rd_addr_p, o_rd_addr_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] p;
        logic [19:0] w;
        bit          mix;
        bit          last;
    } rd_t;
    rd_t q[$];

    wm_block_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_np         (np),
        .i_m          (m),
        .i_blk        (blk),
        .o_rd_en      (o_rd_en),
        .o_rd_addr_p  (o_rd_addr_p),
        .o_rd_addr_w  (o_rd_addr_w),
        .o_stat_valid (o_stat_valid),
        .o_stat_last  (o_stat_last),
        .i_stat_done  (stat_done),
        .i_mix_ready  (mix_ready),
        .o_mix_valid  (o_mix_valid),
        .o_mix_last   (o_mix_last),
        .o_busy       (o_busy),
        .o_image_done (o_image_done),
        .o_cfg_err    (o_cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, o_rd_en, 0);
        check({tag, "_addr_p"}, o_rd_addr_p, 0);
        check({tag, "_addr_w"}, o_rd_addr_w, 0);
        check({tag, "_stat_valid"}, o_stat_valid, 0);
        check({tag, "_stat_last"}, o_stat_last, 0);
        check({tag, "_mix_valid"}, o_mix_valid, 0);
        check({tag, "_mix_last"}, o_mix_last, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_image_done"}, o_image_done, 0);
        check({tag, "_cfg_err"}, o_cfg_err, 0);
    endtask

    // Every read of the image in order: per block a statistics pass then a mix pass.
    task automatic build(input int tnp, input int tm, input int tblk);
        rd_t it;
        q.delete();
        for (int by = 0; by < tm; by++)
            for (int bx = 0; bx < tm; bx++)
                for (int pass = 0; pass < 2; pass++)
                    for (int r = 0; r < tblk; r++)
                        for (int c = 0; c < tblk; c++) begin
                            it.p    = 20'(10 + (by * tblk + r) * tnp + bx * tblk + c);
                            it.w    = 20'(int'(it.p) + tnp * tnp);
                            it.mix  = (pass == 1);
                            it.last = (r == tblk - 1) && (c == tblk - 1);
                            q.push_back(it);
                        end
    endtask

    // dly: cycles in WAIT_STAT before stat_done (0 = random 1..4 plus noise during STAT).
    // rmode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,1 at the start of block0 mix.
    task automatic run_image(input int tnp, input int tm, input int tblk, input int dly,
                             input int rmode, input int exp_done, input int again_cyc,
                             input int abort_after);
        int   cyc, pops, total, wcnt, ps;
        bit   psv, psl, pmv, pml, mid_stat, mid_mix, done_seen;
        logic [3:0] pat;
        rd_t  it;
        pat = 4'b1001;
        build(tnp, tm, tblk);
        total = q.size();
        @(posedge clk); #1;
        np = 10'(tnp); m = 7'(tm); blk = 7'(tblk);
        start = 1'b1; stat_done = 1'b0; mix_ready = 1'b1;
        @(negedge clk);
        {psv, psl, pmv, pml, mid_stat, mid_mix, done_seen} = '0;
        wcnt = 0; ps = -100; pops = 0;
        for (cyc = 1; cyc <= BOUND && !done_seen; cyc++) begin
            @(posedge clk); #1;
            start     = (again_cyc == cyc);
            stat_done = (wcnt == 1) || (dly == 0 && mid_stat && $urandom_range(0, 1) == 1);
            if (wcnt > 0) wcnt--;
            case (rmode)
                0:       mix_ready = 1'b1;
                1:       mix_ready = ($urandom_range(0, 3) != 0);
                default: mix_ready = (cyc >= ps && cyc < ps + 4) ? pat[cyc - ps] : 1'b1;
            endcase
            @(negedge clk);
            if (o_image_done === 1'b1) begin
                done_seen = 1'b1;
                if (exp_done >= 0) check("done_cycle", cyc, exp_done);
            end else begin
                check("busy", o_busy, 1);
            end
            check("cfg_err_run", o_cfg_err, 0);
            check("stat_valid", o_stat_valid, psv);
            check("stat_last", o_stat_last, psl);
            check("mix_valid", o_mix_valid, pmv);
            check("mix_last", o_mix_last, pml);
            if (mid_stat) check("rd_en_stat", o_rd_en, 1);
            if (mid_mix)  check("rd_en_mix", o_rd_en, mix_ready);
            {psv, psl, pmv, pml} = '0;
            if (o_rd_en === 1'b1 && q.size() > 0) begin
                it = q.pop_front();
                pops++;
                check("rd_addr_p", o_rd_addr_p, it.p);
                check("rd_addr_w", o_rd_addr_w, it.w);
                psv = !it.mix; psl = !it.mix && it.last;
                pmv = it.mix;  pml = it.mix && it.last;
                mid_stat = !it.mix && !it.last;
                mid_mix  = it.mix && !it.last;
                if (!it.mix && it.last) begin
                    wcnt = (dly == 0) ? int'($urandom_range(1, 4)) : dly;
                    if (pops == tblk * tblk) ps = cyc + 2;
                end
            end else if (o_rd_en !== 1'b1 && mid_mix && q.size() > 0) begin
                check("hold_addr_p", o_rd_addr_p, q[0].p);
            end
            if (abort_after > 0 && pops == abort_after) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("async_rst");
                repeat (3) begin
                    @(negedge clk);
                    check("rst_rd_en", o_rd_en, 0);
                    check("rst_image_done", o_image_done, 0);
                end
                rst_n = 1'b1;
                return;
            end
        end
        check("image_done", o_image_done, 1);
        check("busy_after", o_busy, 0);
        check("read_count", pops, total);
        $display("run Np=%0d M=%0d Blk=%0d dly=%0d rmode=%0d reads=%0d cycles=%0d",
                 tnp, tm, tblk, dly, rmode, pops, cyc - 1);
    endtask

    // Illegal configuration: nothing is read, Image_Done and cfg_err rise the next cycle.
    task automatic bad_start(input int tnp, input int tm, input int tblk);
        @(posedge clk); #1;
        np = 10'(tnp); m = 7'(tm); blk = 7'(tblk); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("bad_rd_en", o_rd_en, 0);
        check("bad_cfg_err", o_cfg_err, 1);
        check("bad_image_done", o_image_done, 1);
        check("bad_busy", o_busy, 0);
        $display("illegal start Np=%0d M=%0d Blk=%0d cfg_err=%0b", tnp, tm, tblk, o_cfg_err);
    endtask

    initial begin
        int rb, rm, rn;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_image(4, 2, 2, 1, 0, 41, 0, 0);
        @(negedge clk);
        check("done_held", o_image_done, 1);
        run_image(4, 2, 2, 5, 0, 57, 0, 0);
        run_image(4, 2, 2, 1, 2, 43, 0, 0);
        run_image(4, 2, 2, 1, 0, 41, 7, 0);

        bad_start(4, 3, 2);
        run_image(4, 2, 2, 1, 0, 41, 0, 0);
        bad_start(4, 0, 2);
        bad_start(4, 2, 0);
        run_image(4, 2, 2, 1, 0, 41, 0, 0);

        run_image(4, 2, 2, 1, 0, 41, 0, 9);
        run_image(4, 2, 2, 1, 0, 41, 0, 0);

        run_image(6, 3, 2, 0, 1, -1, 0, 0);
        run_image(7, 2, 3, 0, 1, -1, 0, 0);
        run_image(720, 1, 5, 0, 1, -1, 0, 0);
        run_image(9, 2, 4, 3, 0, 2 * 2 * (16 + 3 + 16 + 1) + 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            rb = $urandom_range(1, 4);
            rm = $urandom_range(1, 4);
            rn = rm * rb + $urandom_range(0, 3);
            run_image(rn, rm, rb, 0, 1, -1, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
